e203_ifu_fetch_bridge: RTL and testbench
========================================

// Module: e203_ifu_fetch_bridge
// PURPOSE
// - Sits directly downstream of the IFU fetch-PC stage. Accepts fetch requests (ifu_req_*) and issues ICB read commands.
// - Buffers ICB read responses, returns them in order on ifu_rsp_*, and discards responses belonging to flushed requests.
// - Supports up to OUTS_DEPTH reads in flight. Word-aligns the bus address and selects the halfword for PC[1]=1.
// PARAMETERS
// - PC_SIZE     32  fetch PC / ICB address width
// - INSTR_SIZE  32  instruction and ICB rdata width
// - OUTS_DEPTH  2   max reads in flight; also the depth of the response FIFO and the tag FIFO (>=1)
// PORTS
// - clk            in   1           clock
// - rst            in   1           synchronous reset, active-high
// - ifu_req_valid  in   1           fetch request valid
// - ifu_req_ready  out  1           fetch request accepted
// - ifu_req_pc     in   PC_SIZE     fetch PC; bit0 ignored
// - ifu_rsp_valid  out  1           instruction valid toward IR stage
// - ifu_rsp_ready  in   1           IR stage accepts
// - ifu_rsp_err    out  1           bus error for this fetch
// - ifu_rsp_instr  out  INSTR_SIZE  fetched instruction
// - icb_cmd_valid  out  1           ICB read command valid
// - icb_cmd_ready  in   1           ICB command accepted
// - icb_cmd_addr   out  PC_SIZE     {ifu_req_pc[PC_SIZE-1:2],2'b00}
// - icb_rsp_valid  in   1           ICB response valid
// - icb_rsp_ready  out  1           constant 1; FIFO space is pre-reserved
// - icb_rsp_err    in   1           ICB response error
// - icb_rsp_rdata  in   INSTR_SIZE  ICB read data
// - ifu_flush      in   1           pipeline flush; kill all older fetches
// - ifu_outs_empty out  1           no read in flight, no discard pending, FIFO empty
// BEHAVIOUR
// - Reset: outs_cnt=0, disc_cnt=0, FIFO and tag FIFO empty. Outputs: ifu_rsp_valid=0, ifu_req_ready=0 while rst=1,
//   icb_cmd_valid=0, ifu_outs_empty=1, ifu_rsp_err=0, ifu_rsp_instr=0.
// - Credit: credit = (outs_cnt + disc_cnt + fifo_cnt) < OUTS_DEPTH.
// - Command path is combinational:
//   - icb_cmd_valid = ifu_req_valid & credit & ~ifu_flush
//   - ifu_req_ready = icb_cmd_ready & credit & ~ifu_flush
// - Command handshake: outs_cnt+1. Push ifu_req_pc[1] into the tag FIFO.
// - Live response (icb_rsp_valid & disc_cnt==0): outs_cnt-1. Pop tag. Push {err, instr} into the FIFO.
//   - instr = tag ? {16'h0, rdata[31:16]} : rdata
// - Response while disc_cnt>0: dropped. disc_cnt-1.
// - Output: FIFO head drives ifu_rsp_*. Pop on ifu_rsp_valid & ifu_rsp_ready. Ordering is strictly FIFO.
// - Latency: ICB response to ifu_rsp_valid = 1 cycle (registered).
// - Flush (ifu_flush=1, cycle N):
//   - FIFO and tag FIFO cleared, ifu_rsp_valid=0 from N+1.
//   - disc_cnt <= disc_cnt + outs_cnt - (icb_rsp_valid this cycle). outs_cnt <= 0.
//   - No command issued in cycle N.
// - Flush together with FIFO pop: the flush wins; the popped entry is still consumed in cycle N.
// - Flush together with a live response: that response is dropped and is not counted into disc_cnt.
// - Simultaneous command and response handshakes: counters net to 0 change. FIFO push and pop in the same cycle is allowed when full.
// - Counters never exceed OUTS_DEPTH. A response with outs_cnt==disc_cnt==0 is a protocol error: assertion under simulation, ignored in RTL.
// - Reset mid-transfer: all state cleared at once. Responses to pre-reset commands are the system's responsibility (bus reset together).
// CONFIGURATION
// - E203_IFU_RSP_BYPASS_EN defined: a live ICB response with FIFO empty and ifu_rsp_ready=1 goes combinationally to ifu_rsp_*
//   in the same cycle and is not pushed (0-cycle latency). Otherwise it is pushed as normal.
// - Not defined: all responses are registered through the FIFO (1-cycle latency). No combinational icb_rsp to ifu_rsp path.
// TESTING
// - Single fetch pc=0x80000004, rdata=0x00A00093, ready=1 -> icb_cmd_addr=0x80000004; ifu_rsp_instr=0x00A00093 one cycle after icb_rsp (0 with BYPASS_EN).
// - pc=0x80000006, rdata=0x4501_0001 -> ifu_rsp_instr=0x00004501.
// - OUTS_DEPTH=2, ICB responses withheld, 3 requests back-to-back -> 2 commands accepted; ifu_req_ready=0 on the 3rd until a response returns.
// - 2 in flight, ifu_flush pulse, then 2 old responses, then new request pc=0x100 -> old responses dropped, ifu_rsp_valid stays 0; only pc=0x100 data delivered.
// - ifu_rsp_ready=0 for 10 cycles with 2 fetches -> FIFO full, ifu_req_ready=0; release -> both delivered in order.
// - icb_rsp_err=1 on the 2nd of 3 fetches -> ifu_rsp_err=1 on the 2nd output only; ifu_outs_empty=1 after the last pop.

Source files
------------

// File: rtl/e203_ifu_fetch_bridge.sv
// Fetch bridge between the IFU fetch-PC stage and the ICB instruction bus.
// Latency: ICB response to ifu_rsp_valid is 1 cycle (0 cycles when E203_IFU_RSP_BYPASS_EN is defined).
// Backpressure: ifu_req_ready drops once reads in flight + pending discards + buffered responses reach OUTS_DEPTH.
//
// Optional feature macro: E203_IFU_RSP_BYPASS_EN. It forwards a live response straight to ifu_rsp_* when
// the response FIFO is empty and ifu_rsp_ready=1.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ifu_req_{valid,ready,pc}   fetch request from the PC stage (pc bit0 ignored)
//   ifu_rsp_{valid,ready,err,instr}
//                              in-order fetched instruction toward the IR stage
//   icb_cmd_{valid,ready,addr} ICB read command (word-aligned address)
//   icb_rsp_{valid,ready,err,rdata}
//                              ICB read response (ready tied high)
//   ifu_flush                  kill all older fetches
//   ifu_outs_empty             nothing in flight, nothing to discard, FIFO empty
module e203_ifu_fetch_bridge #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic                  ifu_rsp_err,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  icb_cmd_valid,
  input  logic                  icb_cmd_ready,
  output logic [PC_SIZE-1:0]    icb_cmd_addr,
  input  logic                  icb_rsp_valid,
  output logic                  icb_rsp_ready,
  input  logic                  icb_rsp_err,
  input  logic [INSTR_SIZE-1:0] icb_rsp_rdata,
  input  logic                  ifu_flush,
  output logic                  ifu_outs_empty
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam int SW = CW + 2;
  localparam int HW = INSTR_SIZE / 2;

  logic [CW-1:0] outs_cnt_q, outs_cnt_d;
  logic [CW-1:0] disc_cnt_q, disc_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic                  tag_mem_q  [OUTS_DEPTH];
  logic [INSTR_SIZE:0]   fifo_mem_q [OUTS_DEPTH];

  logic [SW-1:0]         used_sum;
  logic [SW-1:0]         pend_sum;
  logic                  credit;
  logic                  cmd_hs;
  logic                  rsp_live;
  logic                  rsp_drop;
  logic                  rsp_any;
  logic                  rsp_bypass;
  logic                  fifo_nempty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [INSTR_SIZE-1:0] rsp_instr;
  logic [INSTR_SIZE:0]   out_dat;
  logic                  unused_pc0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTS_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign unused_pc0 = ifu_req_pc[0];

  // Every slot that could still produce an output consumes a credit, so the
  // response FIFO can never overflow and the ICB side never needs backpressure.
  assign used_sum = SW'(outs_cnt_q) + SW'(disc_cnt_q) + SW'(fifo_cnt_q);
  assign pend_sum = SW'(outs_cnt_q) + SW'(disc_cnt_q);
  assign credit   = used_sum < SW'(OUTS_DEPTH);

  assign icb_cmd_valid = ~rst & ifu_req_valid & credit & ~ifu_flush;
  assign ifu_req_ready = ~rst & icb_cmd_ready & credit & ~ifu_flush;
  assign icb_cmd_addr  = {ifu_req_pc[PC_SIZE-1:2], 2'b00};
  assign icb_rsp_ready = 1'b1;
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_drop = icb_rsp_valid & (disc_cnt_q != '0);
  assign rsp_live = icb_rsp_valid & (disc_cnt_q == '0) & (outs_cnt_q != '0);
  assign rsp_any  = icb_rsp_valid & (pend_sum != '0);

  // Tag = PC[1] of the oldest live read: upper halfword is the instruction start.
  assign rsp_instr = tag_mem_q[tag_rd_q] ? {{HW{1'b0}}, icb_rsp_rdata[INSTR_SIZE-1:HW]}
                                         : icb_rsp_rdata;

  assign fifo_nempty = (fifo_cnt_q != '0);

`ifdef E203_IFU_RSP_BYPASS_EN
  assign rsp_bypass = ~rst & rsp_live & ~ifu_flush & ~fifo_nempty & ifu_rsp_ready;
`else
  assign rsp_bypass = 1'b0;
`endif

  assign fifo_push = rsp_live & ~ifu_flush & ~rsp_bypass;
  assign fifo_pop  = ~rst & fifo_nempty & ifu_rsp_ready;

  always_comb begin
    out_dat = '0;
    if (rst) begin
      out_dat = '0;
    end else if (fifo_nempty) begin
      out_dat = fifo_mem_q[fifo_rd_q];
    end else if (rsp_bypass) begin
      out_dat = {icb_rsp_err, rsp_instr};
    end
  end

  assign ifu_rsp_valid  = ~rst & (fifo_nempty | rsp_bypass);
  assign ifu_rsp_err    = out_dat[INSTR_SIZE];
  assign ifu_rsp_instr  = out_dat[INSTR_SIZE-1:0];
  assign ifu_outs_empty = (outs_cnt_q == '0) & (disc_cnt_q == '0) & (fifo_cnt_q == '0);

  always_comb begin
    outs_cnt_d = outs_cnt_q;
    disc_cnt_d = disc_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    if (ifu_flush) begin
      // Everything still on the bus becomes a discard, minus the response
      // arriving right now (which is dropped either way).
      outs_cnt_d = '0;
      disc_cnt_d = CW'(pend_sum - SW'(rsp_any));
      fifo_cnt_d = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end else begin
      outs_cnt_d = outs_cnt_q + CW'(cmd_hs) - CW'(rsp_live);
      disc_cnt_d = disc_cnt_q - CW'(rsp_drop);
      fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
      if (cmd_hs)    tag_wr_d  = ptr_inc(tag_wr_q);
      if (rsp_live)  tag_rd_d  = ptr_inc(tag_rd_q);
      if (fifo_push) fifo_wr_d = ptr_inc(fifo_wr_q);
      if (fifo_pop)  fifo_rd_d = ptr_inc(fifo_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_cnt_q <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      outs_cnt_q <= outs_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
    end
  end

  // Storage needs no reset: contents are only observed through the counters.
  always_ff @(posedge clk) begin
    if (cmd_hs)    tag_mem_q[tag_wr_q]   <= ifu_req_pc[1];
    if (fifo_push) fifo_mem_q[fifo_wr_q] <= {icb_rsp_err, rsp_instr};
  end

`ifndef SYNTHESIS
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    icb_rsp_valid |-> ((outs_cnt_q != '0) || (disc_cnt_q != '0)));
`endif

endmodule

// File: tb/tb_e203_ifu_fetch_bridge.sv
module tb_e203_ifu_fetch_bridge;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic        ifu_rsp_err;
  logic [31:0] ifu_rsp_instr;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        ifu_flush;
  logic        ifu_outs_empty;

  e203_ifu_fetch_bridge #(.PC_SIZE(32), .INSTR_SIZE(32), .OUTS_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_pc     (ifu_req_pc),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_ready  (ifu_rsp_ready),
    .ifu_rsp_err    (ifu_rsp_err),
    .ifu_rsp_instr  (ifu_rsp_instr),
    .icb_cmd_valid  (icb_cmd_valid),
    .icb_cmd_ready  (icb_cmd_ready),
    .icb_cmd_addr   (icb_cmd_addr),
    .icb_rsp_valid  (icb_rsp_valid),
    .icb_rsp_ready  (icb_rsp_ready),
    .icb_rsp_err    (icb_rsp_err),
    .icb_rsp_rdata  (icb_rsp_rdata),
    .ifu_flush      (ifu_flush),
    .ifu_outs_empty (ifu_outs_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: reads on the bus (PC[1] tags), pending discards, and
  // delivered-but-unconsumed {err, instr} entries.
  logic        inflight_q[$];
  int          disc_m = 0;
  logic [32:0] outq[$];
  logic [32:0] bus_q[$];
  logic        hs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic rv, input logic [31:0] pc, input logic crdy,
                      input logic sv, input logic serr, input logic [31:0] sdat,
                      input logic ordy, input logic fl, output logic cmd_done);
    logic credit;
    logic exp_cv;
    logic exp_rr;
    logic t;
    @(negedge clk);
    ifu_req_valid = rv;
    ifu_req_pc    = pc;
    icb_cmd_ready = crdy;
    icb_rsp_valid = sv;
    icb_rsp_err   = serr;
    icb_rsp_rdata = sdat;
    ifu_rsp_ready = ordy;
    ifu_flush     = fl;
    #1;
    credit = (inflight_q.size() + disc_m + outq.size()) < DEPTH;
    exp_cv = rv & credit & ~fl;
    exp_rr = crdy & credit & ~fl;
    chk("req_ready", 64'(ifu_req_ready), 64'(exp_rr));
    chk("cmd_valid", 64'(icb_cmd_valid), 64'(exp_cv));
    if (exp_cv) chk("cmd_addr", 64'(icb_cmd_addr), 64'({pc[31:2], 2'b00}));
    chk("rsp_valid", 64'(ifu_rsp_valid), 64'(outq.size() != 0));
    if (outq.size() != 0) begin
      chk("rsp_instr", 64'(ifu_rsp_instr), 64'(outq[0][31:0]));
      chk("rsp_err", 64'(ifu_rsp_err), 64'(outq[0][32]));
    end
    chk("outs_empty", 64'(ifu_outs_empty),
        64'(inflight_q.size() == 0 && disc_m == 0 && outq.size() == 0));
    chk("icb_rsp_ready", 64'(icb_rsp_ready), 64'(1));
    cmd_done = exp_cv & crdy;
    if (fl) begin
      disc_m = disc_m + inflight_q.size() - (sv ? 1 : 0);
      inflight_q.delete();
      outq.delete();
    end else begin
      if (outq.size() != 0 && ordy) void'(outq.pop_front());
      if (sv) begin
        if (disc_m > 0) disc_m--;
        else begin
          t = inflight_q.pop_front();
          outq.push_back({serr, t ? {16'h0, sdat[31:16]} : sdat});
        end
      end
      if (cmd_done) inflight_q.push_back(pc[1]);
    end
  endtask

  task automatic req(input logic [31:0] pc, input logic ordy);
    step(1'b1, pc, 1'b1, 1'b0, 1'b0, 32'h0, ordy, 1'b0, hs);
  endtask

  task automatic rsp(input logic err, input logic [31:0] d, input logic ordy);
    step(1'b0, 32'h0, 1'b1, 1'b1, err, d, ordy, 1'b0, hs);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, ordy, 1'b0, hs);
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h0; icb_cmd_ready = 1'b1;
    icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = 32'h0;
    ifu_rsp_ready = 1'b1; ifu_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(ifu_req_ready), 64'(0));
    chk("rst_cmd_valid", 64'(icb_cmd_valid), 64'(0));
    chk("rst_rsp_valid", 64'(ifu_rsp_valid), 64'(0));
    chk("rst_outs_empty", 64'(ifu_outs_empty), 64'(1));
    chk("rst_rsp_err", 64'(ifu_rsp_err), 64'(0));
    chk("rst_rsp_instr", 64'(ifu_rsp_instr), 64'(0));
    ifu_req_valid = 1'b0;
    rst = 1'b0;

    // Single aligned fetch.
    req(32'h8000_0004, 1'b1);
    chk("t1_addr", 64'(icb_cmd_addr), 64'(32'h8000_0004));
    rsp(1'b0, 32'h00A0_0093, 1'b1);
    chk("t1_no_same_cycle", 64'(ifu_rsp_valid), 64'(0));
    idle(1'b1);
    chk("t1_instr", 64'(ifu_rsp_instr), 64'(32'h00A0_0093));

    // Halfword-offset fetch.
    req(32'h8000_0006, 1'b1);
    chk("t2_addr", 64'(icb_cmd_addr), 64'(32'h8000_0004));
    rsp(1'b0, 32'h4501_0001, 1'b1);
    idle(1'b1);
    chk("t2_instr", 64'(ifu_rsp_instr), 64'(32'h0000_4501));
    idle(1'b1);

    // Credit limit: third back-to-back request is held.
    req(32'h10, 1'b1);
    chk("t3_rdy1", 64'(ifu_req_ready), 64'(1));
    req(32'h14, 1'b1);
    chk("t3_rdy2", 64'(ifu_req_ready), 64'(1));
    req(32'h18, 1'b1);
    chk("t3_rdy3", 64'(ifu_req_ready), 64'(0));
    rsp(1'b0, 32'h1111_0010, 1'b1);
    rsp(1'b0, 32'h2222_0014, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with two reads in flight; stale responses must vanish.
    req(32'h200, 1'b1);
    req(32'h204, 1'b1);
    step(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, hs);
    chk("t4_no_cmd_on_flush", 64'(icb_cmd_valid), 64'(0));
    rsp(1'b0, 32'hDEAD_0200, 1'b1);
    chk("t4_drop1", 64'(ifu_rsp_valid), 64'(0));
    rsp(1'b0, 32'hDEAD_0204, 1'b1);
    chk("t4_drop2", 64'(ifu_rsp_valid), 64'(0));
    idle(1'b1);
    chk("t4_valid_low", 64'(ifu_rsp_valid), 64'(0));
    chk("t4_empty", 64'(ifu_outs_empty), 64'(1));
    req(32'h100, 1'b1);
    rsp(1'b0, 32'hCAFE_0100, 1'b1);
    idle(1'b1);
    chk("t4_new_instr", 64'(ifu_rsp_instr), 64'(32'hCAFE_0100));
    idle(1'b1);

    // Output stall fills the FIFO, then drains in order.
    req(32'h300, 1'b0);
    req(32'h304, 1'b0);
    rsp(1'b0, 32'hA000_0300, 1'b0);
    rsp(1'b0, 32'hB000_0304, 1'b0);
    for (int i = 0; i < 6; i++) req(32'h308, 1'b0);
    chk("t5_full_block", 64'(ifu_req_ready), 64'(0));
    idle(1'b1);
    chk("t5_first", 64'(ifu_rsp_instr), 64'(32'hA000_0300));
    idle(1'b1);
    chk("t5_second", 64'(ifu_rsp_instr), 64'(32'hB000_0304));
    idle(1'b1);

    // Error on the middle of three fetches.
    req(32'h400, 1'b1);
    req(32'h404, 1'b1);
    rsp(1'b0, 32'h0000_0400, 1'b1);
    rsp(1'b1, 32'h0000_0404, 1'b1);
    chk("t6_err1", 64'(ifu_rsp_err), 64'(0));
    req(32'h408, 1'b1);
    chk("t6_err2", 64'(ifu_rsp_err), 64'(1));
    rsp(1'b0, 32'h0000_0408, 1'b1);
    idle(1'b1);
    chk("t6_err3", 64'(ifu_rsp_err), 64'(0));
    idle(1'b1);
    chk("t6_empty", 64'(ifu_outs_empty), 64'(1));

    // Randomised traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      logic        rv, crdy, sv, ordy, fl;
      logic [31:0] pc;
      logic [32:0] e;
      logic [32:0] head;
      rv   = ($urandom_range(0, 9) < 7);
      pc   = $urandom;
      crdy = ($urandom_range(0, 9) < 8);
      ordy = ((i % 200) < 40) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      sv   = (bus_q.size() != 0) && ($urandom_range(0, 1) == 1);
      head = sv ? bus_q[0] : 33'h0;
      step(rv, pc, crdy, sv, head[32], head[31:0], ordy, fl, hs);
      if (sv) void'(bus_q.pop_front());
      if (hs) begin
        e[32]   = ($urandom_range(0, 7) == 0);
        e[31:0] = $urandom;
        bus_q.push_back(e);
      end
    end

    // Drain everything still on the bus or in the FIFO.
    for (int i = 0; i < 50; i++) begin
      logic [32:0] head;
      logic        sv;
      sv   = (bus_q.size() != 0);
      head = sv ? bus_q[0] : 33'h0;
      step(1'b0, 32'h0, 1'b1, sv, head[32], head[31:0], 1'b1, 1'b0, hs);
      if (sv) void'(bus_q.pop_front());
    end
    chk("final_empty", 64'(ifu_outs_empty), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
